// File: rtl/dm_wb_cache_if.sv
// dm_wb_cache_if -- bus bundle between the core, the cache and block memory.
//
// Signals:
//   proc_read/proc_write/proc_addr/proc_wdata : core request (core -> cache)
//   proc_stall/proc_rdata                     : core response (cache -> core)
//   mem_read/mem_write/mem_addr/mem_wdata     : block request (cache -> memory)
//   mem_rdata/mem_ready                       : block response (memory -> cache)
//
// Modports:
//   slave  : the cache's view (serves the core, drives memory requests)
//   master : the environment's view (core plus memory together)
interface dm_wb_cache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_wb_cache.sv
// dm_wb_cache -- direct-mapped, write-back, write-allocate cache between a
// word-addressed core port and a 128-bit block memory.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears state and all line contents
//   bus   : dm_wb_cache_if.slave (core request/stall/rdata, memory block bus)
//
// Parameter:
//   SETS  : number of lines (power of two, >= 2)
//
// Optional feature (macro DCACHE_ALLOC_BYPASS_EN):
//   When defined, the refill cycle that sees mem_ready also serves the core:
//   reads are forwarded from mem_rdata and writes are merged into the
//   incoming block, saving the extra IDLE hit cycle after a miss.
module dm_wb_cache #(
  parameter int SETS = 8
) (
  input logic          clk,
  input logic          rst_n,
  dm_wb_cache_if.slave bus
);

  localparam int IDX = $clog2(SETS);
  localparam int TAG = 28 - IDX;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;

  logic [1:0]     state_reg;
  logic [1:0]     state_next;
  logic [SETS-1:0] valid_reg;
  logic [SETS-1:0] dirty_reg;
  logic [TAG-1:0] tag_reg  [SETS];
  logic [127:0]   data_reg [SETS];

  logic [IDX-1:0] idx;
  logic [TAG-1:0] tag_in;
  logic [1:0]     word;
  logic           req;
  logic           hit;
  logic [127:0]   cur_line;
  logic           fill;
  logic           bypass;
  logic           idle_write_hit;
  logic           merge;
  logic [127:0]   base_line;
  logic [127:0]   line_next;
  logic [127:0]   rd_line;
  logic           line_we;

  assign idx      = bus.proc_addr[IDX+1:2];
  assign tag_in   = bus.proc_addr[29:IDX+2];
  assign word     = bus.proc_addr[1:0];
  assign req      = bus.proc_read | bus.proc_write;
  assign hit      = valid_reg[idx] && (tag_reg[idx] == tag_in);
  assign cur_line = data_reg[idx];

  // Refill completes in this cycle.
  assign fill = (state_reg == ALLOCATE) && bus.mem_ready;

`ifdef DCACHE_ALLOC_BYPASS_EN
  assign bypass = fill;
`else
  assign bypass = 1'b0;
`endif

  assign idle_write_hit = (state_reg == IDLE) && bus.proc_write && hit;

  // A write lands either on an IDLE hit or, with bypass, into the refill block.
  assign merge     = idle_write_hit || (bypass && bus.proc_write);
  assign base_line = fill ? bus.mem_rdata : cur_line;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign line_next[gi*32 +: 32] = (merge && (word == 2'(gi))) ?
                                      bus.proc_wdata : base_line[gi*32 +: 32];
    end
  endgenerate

  assign line_we = idle_write_hit || fill;

  // Read path: the indexed line, or the incoming block while bypassing.
  assign rd_line        = bypass ? bus.mem_rdata : cur_line;
  assign bus.proc_rdata = rd_line[{word, 5'd0} +: 32];

  always_comb begin
    state_next     = state_reg;
    bus.proc_stall = 1'b1;
    case (state_reg)
      IDLE: begin
        bus.proc_stall = req && !hit;
        if (req && !hit)
          state_next = (valid_reg[idx] && dirty_reg[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (bus.mem_ready)
          state_next = ALLOCATE;
      end
      ALLOCATE: begin
        bus.proc_stall = !bypass;
        if (bus.mem_ready)
          state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory strobes come straight from the state register so they only move
  // on clock edges (or asynchronously with reset).
  assign bus.mem_write = (state_reg == WRITEBACK);
  assign bus.mem_read  = (state_reg == ALLOCATE);
  assign bus.mem_addr  = (state_reg == WRITEBACK) ? {tag_reg[idx], idx} :
                         (state_reg == ALLOCATE)  ? bus.proc_addr[29:2] : 28'd0;
  assign bus.mem_wdata = (state_reg == WRITEBACK) ? cur_line : 128'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_reg[i]  <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (line_we) begin
        valid_reg[idx] <= 1'b1;
        dirty_reg[idx] <= merge;
        tag_reg[idx]   <= tag_in;
        data_reg[idx]  <= line_next;
      end
    end
  end

endmodule

// File: doc/dm_wb_cache.md
# dm_wb_cache

Direct-mapped, write-back, write-allocate cache that sits between the pipeline core's word-addressed cache port (read/write strobe, 30-bit word address, stall-back handshake) and a 128-bit block-wide memory. It is the responder for the core's instruction or data fetch requests and the initiator toward slow memory. It answers hits with zero stall and serialises write-back and refill on misses.

## Interface
Parameters:
- SETS, 8, number of cache lines. Power of two, at least 2. IDX = log2(SETS). TAG = 28 − IDX.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- proc_read  in  1  core read request, level.
- proc_write  in  1  core write request, level. Write wins if both are high.
- proc_addr  in  30  word address. [1:0] is the word in the block, [IDX+1:2] is the index, [29:IDX+2] is the tag.
- proc_wdata  in  32  write data.
- proc_stall  out  1  high while the current request is not yet served.
- proc_rdata  out  32  word selected by proc_addr from the indexed line.
- mem_read  out  1  block refill request.
- mem_write  out  1  block write-back request.
- mem_addr  out  28  block address.
- mem_wdata  out  128  victim block. Word n is [32n+31:32n].
- mem_rdata  in  128  refill block, same word packing.
- mem_ready  in  1  one-cycle completion pulse from memory.

## Operation
- State per line: valid, dirty, tag, and four 32-bit words.
- Controller states:
  - IDLE (compare)
  - WRITEBACK
  - ALLOCATE
- hit = valid[idx] & (tag[idx] == addr tag).
- IDLE, no request: proc_stall = 0 and no memory traffic.
- IDLE, read hit: proc_stall = 0. proc_rdata = the addressed word, combinational.
- IDLE, write hit: proc_stall = 0. The word is written at the clock edge and dirty is set to 1.
- IDLE, miss: proc_stall = 1, combinational.
  - Line valid and dirty: next state is WRITEBACK.
  - Otherwise: next state is ALLOCATE.
- WRITEBACK:
  - mem_write = 1. mem_addr = {stored tag, idx}. mem_wdata = the stored block.
  - All three are held stable until mem_ready.
  - On mem_ready, go to ALLOCATE.
- ALLOCATE:
  - mem_read = 1. mem_addr = proc_addr[29:2], held until mem_ready.
  - On mem_ready, the line takes mem_rdata, the tag is set, valid = 1, dirty = 0, and the state returns to IDLE.
  - The retried access then hits in IDLE, so a write merges at that point.
- proc_stall = 1 in WRITEBACK and ALLOCATE.
- mem_read and mem_write are decoded from the state register. They are never high together and drop in the cycle after mem_ready.
- mem_addr and mem_wdata are 0 outside their own state.
- The core holds its request stable while stalled; the cache does not latch it.
- Reset, at any time including mid-miss: state goes to IDLE and all valid, dirty, tag and data bits clear to 0, asynchronously.
  - mem_read and mem_write fall immediately.
  - An in-flight mem_ready after reset is ignored.

## Timing
- Reset values:
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - proc_rdata = 0, because the data array is zeroed.
  - proc_stall = 0 with no request, and 1 with any request, since every line is invalid.
- Hit: zero stall cycles.
- Clean miss, where mem_read is high for N cycles including the mem_ready cycle: stall lasts N+1 cycles. The data is valid in the first non-stall cycle.
- Dirty miss, with Nw write cycles and Nr read cycles: stall lasts Nw+Nr+1 cycles.
- Memory request outputs change only on clock edges, except through reset.

## Configuration
- DCACHE_ALLOC_BYPASS_EN defined:
  - In the ALLOCATE cycle where mem_ready = 1, proc_stall = 0.
  - For a read, proc_rdata is forwarded from the addressed word of mem_rdata.
  - For a write, proc_wdata is merged into the incoming block and the line is written with dirty = 1.
  - Clean miss stall becomes N cycles.
- DCACHE_ALLOC_BYPASS_EN undefined: behaviour is exactly as in Operation, with the extra IDLE hit cycle.

## Test plan
- Cold read miss, no macro:
  - After reset, read proc_addr 30'h10; memory answers 3 cycles after request with {32'hD,32'hC,32'hB,32'hA}.
  - mem_read high with mem_addr 28'h4 for 3 cycles, proc_stall high for 4 cycles, then proc_rdata = 32'hA with stall 0.
- Write hit:
  - Write 32'h1234 to 30'h11.
  - No stall and no memory strobe; a read of 30'h11 returns 32'h1234 in the same cycle.
- Dirty conflict:
  - Read 30'h30, which has the same index 4 and tag 1.
  - mem_write first with mem_addr 28'h4 and mem_wdata = {D,C,32'h1234,A}; after mem_ready, mem_read with mem_addr 28'hC.
- Clean conflict: a read miss on a clean valid line produces no mem_write; only ALLOCATE runs.
- Reset mid-refill:
  - Drop rst_n during ALLOCATE.
  - mem_read falls in the same cycle; re-reading 30'h10 misses again.
- Macro on: repeat scenario 1. proc_stall is low in the mem_ready cycle with proc_rdata = 32'hA, for 3 stall cycles total.
